// File: rtl/quad_decoder_counter.sv
// Quadrature A/B decoder: per-channel synchroniser + glitch filter, x4 decode,
// wrapping position counter with step/dir/wrap pulses and a sticky error flag.

module quad_decoder_counter_chan #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    input  logic load,
    output logic sync,
    output logic level
);
    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [SYNC_STAGES-1:0] sh;
    logic [CW-1:0]          cnt;

    assign sync = sh[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh    <= '0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sh <= {sh[SYNC_STAGES-2:0], raw};
            if (load) begin
                level <= sync;
                cnt   <= '0;
            end else if (sync != level) begin
                // accept on the edge where the mismatch run reaches FILTER_LEN
                if (cnt == CW'(FILTER_LEN - 1)) begin
                    level <= sync;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

module quad_decoder_counter #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] pos,
    output logic             dir,
    output logic             step,
    output logic             wrap,
    output logic             err,
    output logic             ready
);
    localparam int INIT_CYC = SYNC_STAGES + FILTER_LEN;
    localparam int ICW      = $clog2(INIT_CYC + 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t         state;
    logic [ICW-1:0] init_cnt;
    logic [1:0]     raw, sync, lvl, prv;
    logic           load, mv_up, mv_dn, illegal;

    assign raw  = {enc_a, enc_b};
    assign load = (state == INIT);

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_chan
            quad_decoder_counter_chan #(
                .SYNC_STAGES(SYNC_STAGES),
                .FILTER_LEN (FILTER_LEN)
            ) u_chan (
                .clk  (clk),
                .rst_n(rst_n),
                .raw  (raw[g]),
                .load (load),
                .sync (sync[g]),
                .level(lvl[g])
            );
        end
    endgenerate

    // {a,b}: up is 00->10->11->01->00, down is the reverse
    always_comb begin
        mv_up = 1'b0;
        mv_dn = 1'b0;
        case ({prv, lvl})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: mv_up = 1'b1;
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: mv_dn = 1'b1;
            default: ;
        endcase
    end
    assign illegal = ((prv ^ lvl) == 2'b11);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= INIT;
            init_cnt <= '0;
            prv      <= '0;
            pos      <= '0;
            dir      <= 1'b0;
            step     <= 1'b0;
            wrap     <= 1'b0;
            err      <= 1'b0;
            ready    <= 1'b0;
        end else begin
            step <= 1'b0;
            wrap <= 1'b0;
            case (state)
                INIT: begin
                    // track the synchronised pins so RUN starts with prv == level
                    prv <= sync;
                    if (init_cnt == ICW'(INIT_CYC - 1)) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end else begin
                        init_cnt <= init_cnt + ICW'(1);
                    end
                end
                RUN: begin
                    prv <= lvl;
                    if (clr) begin
                        pos <= '0;
                        err <= 1'b0;
                    end else begin
                        if (illegal) err <= 1'b1;
                        if (en && (mv_up || mv_dn)) begin
                            step <= 1'b1;
                            dir  <= mv_up;
                            pos  <= mv_up ? pos + WIDTH'(1) : pos - WIDTH'(1);
                            wrap <= mv_up ? (pos == '1) : (pos == '0);
                        end
                    end
                end
                default: state <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_quad_decoder_counter.sv
// Self-checking bench: directed scenarios plus randomized moves against a
// gray-phase position model.

module tb_quad_decoder_counter;
    localparam int WIDTH = 8;
    localparam int LAT   = 2 + 3 + 1;   // first-sample edge is one past the drive negedge
    localparam int MODV  = 1 << WIDTH;

    logic             clk, rst_n, enc_a, enc_b, en, clr;
    logic [WIDTH-1:0] pos;
    logic             dir, step, wrap, err, ready;

    quad_decoder_counter #(.WIDTH(WIDTH), .SYNC_STAGES(2), .FILTER_LEN(3)) dut (
        .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b), .en(en), .clr(clr),
        .pos(pos), .dir(dir), .step(step), .wrap(wrap), .err(err), .ready(ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc = 0, nsteps = 0, nwraps = 0, last_step_cyc = -1;
    int m_pos = 0, m_steps = 0, m_wraps = 0, chg_cyc = 0;
    logic m_err = 1'b0, m_dir = 1'b0, a_q = 1'b0, b_q = 1'b0;

    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (step) begin nsteps++; last_step_cyc = cyc; end
        if (wrap) nwraps++;
    end

    function automatic int phase(input logic a, input logic b);
        case ({a, b})
            2'b00: return 0;
            2'b10: return 1;
            2'b11: return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] unphase(input int p);
        case (p & 3)
            0: return 2'b00;
            1: return 2'b10;
            2: return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic move(input logic na, input logic nb, input int hold);
        int d;
        d = (phase(na, nb) - phase(a_q, b_q)) & 3;
        if (d == 2) m_err = 1'b1;
        else if (d != 0 && en) begin
            if (d == 1) begin
                if (m_pos == MODV - 1) m_wraps++;
                m_pos = (m_pos + 1) % MODV;
                m_dir = 1'b1;
            end else begin
                if (m_pos == 0) m_wraps++;
                m_pos = (m_pos + MODV - 1) % MODV;
                m_dir = 1'b0;
            end
            m_steps++;
        end
        chg_cyc = cyc;
        enc_a = na; enc_b = nb; a_q = na; b_q = nb;
        tick(hold);
    endtask

    task automatic move_rel(input int d, input int hold);
        logic [1:0] n;
        n = unphase(phase(a_q, b_q) + d);
        move(n[1], n[0], hold);
    endtask

    task automatic glitch(input logic on_a, input int len);
        if (on_a) enc_a = ~a_q; else enc_b = ~b_q;
        tick(len);
        enc_a = a_q; enc_b = b_q;
        tick(3);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        m_pos = 0; m_err = 1'b0;
        tick(1);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pos"},   32'(pos),    32'(m_pos));
        chk({tag, ".err"},   32'(err),    32'(m_err));
        chk({tag, ".dir"},   32'(dir),    32'(m_dir));
        chk({tag, ".steps"}, 32'(nsteps), 32'(m_steps));
        chk({tag, ".wraps"}, 32'(nwraps), 32'(m_wraps));
    endtask

    initial begin
        int base;
        rst_n = 1'b0; enc_a = 1'b1; enc_b = 1'b1; en = 1'b1; clr = 1'b0;
        a_q = 1'b1; b_q = 1'b1;
        tick(3);
        chk("rst.pos", 32'(pos), 0);
        chk("rst.ready", 32'(ready), 0);
        chk("rst.flags", 32'({dir, step, wrap, err}), 0);

        // init immunity with pins already at 11
        rst_n = 1'b1;
        tick(4);
        chk("init.ready_early", 32'(ready), 0);
        tick(1);
        chk("init.ready", 32'(ready), 1);
        tick(10);
        check_all("init");

        move(1'b0, 1'b1, 8);
        move(1'b0, 1'b0, 8);
        check_all("to00");
        do_clr();
        check_all("clr0");

        // up x4 with latency check on each step
        move(1'b1, 1'b0, 8); chk("up.lat1", 32'(last_step_cyc - chg_cyc), LAT);
        move(1'b1, 1'b1, 8); chk("up.lat2", 32'(last_step_cyc - chg_cyc), LAT);
        move(1'b0, 1'b1, 8); chk("up.lat3", 32'(last_step_cyc - chg_cyc), LAT);
        move(1'b0, 1'b0, 8); chk("up.lat4", 32'(last_step_cyc - chg_cyc), LAT);
        check_all("up");
        chk("up.pos4", 32'(pos), 4);

        // down across zero
        do_clr();
        move(1'b0, 1'b1, 8);
        check_all("dn1");
        chk("dn.pos255", 32'(pos), 255);
        move(1'b1, 1'b1, 8);
        move(1'b1, 1'b0, 8);
        chk("dn.pos253", 32'(pos), 253);
        move(1'b0, 1'b0, 8);
        check_all("dn");

        // glitch filter
        base = nsteps;
        glitch(1'b1, 2);
        tick(6);
        chk("glitch2.steps", 32'(nsteps - base), 0);
        check_all("glitch2");
        move(1'b1, 1'b0, 3);
        move(1'b0, 1'b0, 8);
        chk("pulse3.steps", 32'(nsteps - base), 2);
        check_all("pulse3");

        // illegal double change, then clear
        move(1'b1, 1'b1, 8);
        chk("illegal.err", 32'(err), 1);
        check_all("illegal");
        do_clr();
        check_all("illegal_clr");

        // en=0 freezes; re-enable gives no catch-up
        en = 1'b0;
        for (int i = 0; i < 4; i++) move_rel(1, 8);
        check_all("en0");
        en = 1'b1;
        tick(10);
        check_all("en1");

        // clr coincident with a step: step dropped
        move_rel(1, 8);
        base = nsteps;
        begin
            logic [1:0] n;
            n = unphase(phase(a_q, b_q) + 1);
            chg_cyc = cyc;
            enc_a = n[1]; enc_b = n[0]; a_q = n[1]; b_q = n[0];
        end
        tick(LAT - 1);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        m_pos = 0; m_err = 1'b0;
        tick(8);
        chk("clrstep.steps", 32'(nsteps - base), 0);
        check_all("clrstep");

        // randomized moves, glitches and illegal changes
        for (int c = 0; c < 25; c++) begin
            en = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < 6; i++) begin
                int r, h;
                r = $urandom_range(0, 9);
                h = $urandom_range(3, 8);
                if (r < 4)       move_rel(1, h);
                else if (r < 7)  move_rel(3, h);
                else if (r < 8)  move(~a_q, ~b_q, h);
                else             glitch($urandom_range(0, 1) == 1, $urandom_range(1, 2));
            end
            tick(8);
            check_all("rnd");
            if ($urandom_range(0, 3) == 0) begin
                do_clr();
                check_all("rnd_clr");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
